// File: rtl/obi_ram_arbiter.sv
// rtl/obi_ram_arbiter.sv - two-master OBI arbiter in front of a single-port OBI RAM slave
// Define OBI_ARB_FIXED_PRIO_EN to let the LSU (m1) win every conflict instead of round-robin.
module obi_ram_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             m_req_i,
  output logic [1:0]             m_gnt_o,
  input  logic [1:0][ADDR_W-1:0] m_addr_i,
  input  logic [1:0]             m_we_i,
  input  logic [1:0][3:0]        m_be_i,
  input  logic [1:0][31:0]       m_wdata_i,
  output logic [1:0]             m_rvalid_o,
  output logic [31:0]            m_rdata_o,
  output logic                   s_req_o,
  input  logic                   s_gnt_i,
  output logic [ADDR_W-1:0]      s_addr_o,
  output logic                   s_we_o,
  output logic [3:0]             s_be_o,
  output logic [31:0]            s_wdata_o,
  input  logic                   s_rvalid_i,
  input  logic [31:0]            s_rdata_i,
  output logic                   err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             id_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             last_grant_q, lock_q, lock_sel_q, err_q;
  logic             sel, full, empty, handshake, pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (MAX_OUTSTANDING == 1) return '0;
    return p + 1'b1;
  endfunction

  assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

  // A stalled request keeps its master until the slave grants it.
  always_comb begin
    sel = 1'b0;
    if (lock_q && m_req_i[lock_sel_q]) begin
      sel = lock_sel_q;
    end else begin
      case (m_req_i)
        2'b10: sel = 1'b1;
`ifdef OBI_ARB_FIXED_PRIO_EN
        2'b11: sel = 1'b1;
`else
        2'b11: sel = ~last_grant_q;
`endif
        default: sel = 1'b0;
      endcase
    end
  end

  assign s_req_o   = (|m_req_i) && !full;
  assign s_addr_o  = m_addr_i[sel];
  assign s_we_o    = m_we_i[sel];
  assign s_be_o    = m_be_i[sel];
  assign s_wdata_o = m_wdata_i[sel];

  assign handshake = s_req_o && s_gnt_i;
  assign m_gnt_o   = handshake ? (sel ? 2'b10 : 2'b01) : 2'b00;

  assign pop        = s_rvalid_i && !empty;
  assign m_rvalid_o = pop ? (id_q[rd_ptr_q] ? 2'b10 : 2'b01) : 2'b00;
  assign m_rdata_o  = s_rdata_i;
  assign err_o      = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) id_q[i] <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      lock_q       <= 1'b0;
      lock_sel_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (handshake) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= next_ptr(wr_ptr_q);
        last_grant_q   <= sel;
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (handshake && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !handshake) begin
        count_q <= count_q - 1'b1;
      end
      lock_q     <= s_req_o && !s_gnt_i;
      lock_sel_q <= sel;
      err_q      <= s_rvalid_i && empty;
    end
  end

endmodule
